frame_unpack10: RTL and testbench

- Receive-side counterpart of the 10-word + trailer output selector.
- Accepts a byte stream one byte per valid cycle: 10 data bytes (index 0..9), then the trailer byte 8'hB7 (index 10).
- On a correct trailer, publishes the 10 bytes in parallel on W0..W9 and pulses frame_valid.
- Malformed frames are discarded; the block resynchronises on the next trailer byte.

---
 rtl/frame_unpack10.sv | 168 ++++++++++++++++
 tb/tb_frame_unpack10.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/frame_unpack10.sv
`default_nettype none
// ============================================================================
// Module      : frame_unpack10
// Description : Receive-side frame unpacker. Collects 10 data bytes followed
//               by a trailer byte. On a matching trailer the 10 bytes are
//               published in parallel on W0..W9 with a one-cycle frame_valid
//               pulse. On a mismatch a one-cycle frame_err pulse is raised
//               and the block drops bytes until the next trailer.
// Ports       : clk         - rising-edge clock
//               rst         - synchronous active-high reset
//               in_valid    - in_data carries a byte this cycle
//               in_data     - stream byte
//               in_ready    - block accepts a byte this cycle
//               W0..W9      - last good frame, byte k on Wk
//               frame_valid - one-cycle pulse, W0..W9 just updated
//               frame_err   - one-cycle pulse, trailer mismatch detected
//               idx         - index the next accepted byte will occupy
// Revision    : 1.0 - initial release
// ============================================================================
module frame_unpack10 #(
    parameter logic [7:0] TRAILER = 8'hB7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] W0,
    output logic [7:0] W1,
    output logic [7:0] W2,
    output logic [7:0] W3,
    output logic [7:0] W4,
    output logic [7:0] W5,
    output logic [7:0] W6,
    output logic [7:0] W7,
    output logic [7:0] W8,
    output logic [7:0] W9,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [3:0] idx
);

    localparam logic [1:0] c_ST_COLLECT = 2'd0;
    localparam logic [1:0] c_ST_CHECK   = 2'd1;
    localparam logic [1:0] c_ST_PUBLISH = 2'd2;
    localparam logic [1:0] c_ST_RESYNC  = 2'd3;

    localparam logic [3:0] c_IDX_LAST_DATA = 4'd9;
    localparam logic [3:0] c_IDX_TRAILER   = 4'd10;

    logic [1:0] r_state;
    logic [3:0] r_idx;
    logic [7:0] r_shadow [10];
    logic [7:0] r_w      [10];
    logic       r_frame_valid;
    logic       r_frame_err;

    logic [1:0] w_state_nxt;
    logic [3:0] w_idx_nxt;
    logic       w_accept;
    logic       w_wr_shadow;
    logic       w_publish;
    logic       w_err;

    // The only non-ready cycle is PUBLISH, so the source must hold a byte
    // offered there until the following cycle.
    assign in_ready = (r_state != c_ST_PUBLISH);
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Next-state / control decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wr_shadow = 1'b0;
        w_publish   = 1'b0;
        w_err       = 1'b0;

        case (r_state)
            c_ST_COLLECT: begin
                // Data bytes are never compared with the trailer value.
                if (w_accept) begin
                    w_wr_shadow = 1'b1;
                    if (r_idx == c_IDX_LAST_DATA) begin
                        w_state_nxt = c_ST_CHECK;
                        w_idx_nxt   = c_IDX_TRAILER;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            c_ST_CHECK: begin
                if (w_accept) begin
                    w_idx_nxt = 4'd0;
                    if (in_data == TRAILER) begin
                        w_state_nxt = c_ST_PUBLISH;
                        w_publish   = 1'b1;
                    end else begin
                        w_state_nxt = c_ST_RESYNC;
                        w_err       = 1'b1;
                    end
                end
            end
            c_ST_PUBLISH: begin
                w_state_nxt = c_ST_COLLECT;
                w_idx_nxt   = 4'd0;
            end
            c_ST_RESYNC: begin
                w_idx_nxt = 4'd0;
                if (w_accept && (in_data == TRAILER)) begin
                    w_state_nxt = c_ST_COLLECT;
                end
            end
            default: begin
                w_state_nxt = c_ST_COLLECT;
                w_idx_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, shadow buffer and published-word registers. The publish
    // decision is registered at the trailer edge, so W0..W9 and
    // frame_valid become visible together during the PUBLISH cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_COLLECT;
            r_idx         <= 4'd0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            for (int k = 0; k < 10; k++) begin
                r_shadow[k] <= 8'h00;
                r_w[k]      <= 8'h00;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_idx         <= w_idx_nxt;
            r_frame_valid <= w_publish;
            r_frame_err   <= w_err;
            for (int k = 0; k < 10; k++) begin
                if (w_wr_shadow && (r_idx == 4'(k))) begin
                    r_shadow[k] <= in_data;
                end
                if (w_publish) begin
                    r_w[k] <= r_shadow[k];
                end
            end
        end
    end

    assign W0          = r_w[0];
    assign W1          = r_w[1];
    assign W2          = r_w[2];
    assign W3          = r_w[3];
    assign W4          = r_w[4];
    assign W5          = r_w[5];
    assign W6          = r_w[6];
    assign W7          = r_w[7];
    assign W8          = r_w[8];
    assign W9          = r_w[9];
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign idx         = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_frame_unpack10.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_unpack10
// Description : Directed self-checking bench for frame_unpack10. Inputs are
//               driven 1 time unit after each rising edge and outputs are
//               checked at that same point, away from the active edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_unpack10;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] W0, W1, W2, W3, W4, W5, W6, W7, W8, W9;
    logic       frame_valid;
    logic       frame_err;
    logic [3:0] idx;

    int checks;
    int failures;

    logic [79:0] w_all;
    assign w_all = {W9, W8, W7, W6, W5, W4, W3, W2, W1, W0};

    frame_unpack10 #(.TRAILER(8'hB7)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .W0          (W0),
        .W1          (W1),
        .W2          (W2),
        .W3          (W3),
        .W4          (W4),
        .W5          (W5),
        .W6          (W6),
        .W7          (W7),
        .W8          (W8),
        .W9          (W9),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .idx         (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One byte offered for exactly one edge.
    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    // Expected W0..W9 packing for the incrementing frame base, base+1, ...
    function automatic logic [79:0] seq(input logic [7:0] base);
        logic [79:0] r;
        for (int k = 0; k < 10; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // ---------------- Reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        chk("rst_idx", 80'(idx), 80'd0);
        chk("rst_fv", 80'(frame_valid), 80'd0);
        chk("rst_fe", 80'(frame_err), 80'd0);
        chk("rst_ready", 80'(in_ready), 80'd1);
        chk("rst_w", w_all, 80'd0);

        // ---------------- Good frame, back-to-back ----------------
        for (int k = 0; k < 10; k++) begin
            send(8'h10 + 8'(k));
            chk($sformatf("seq_idx_%0d", k), 80'(idx), 80'(k + 1));
            chk("seq_fv_quiet", 80'(frame_valid), 80'd0);
        end
        send(8'hB7);
        chk("good1_fv", 80'(frame_valid), 80'd1);
        chk("good1_fe", 80'(frame_err), 80'd0);
        chk("good1_ready", 80'(in_ready), 80'd0);
        chk("good1_idx", 80'(idx), 80'd0);
        chk("good1_w", w_all, seq(8'h10));
        idle();
        chk("good1_fv_end", 80'(frame_valid), 80'd0);
        chk("good1_ready_end", 80'(in_ready), 80'd1);

        // ---------------- Bad trailer, then resync ----------------
        for (int k = 0; k < 10; k++) send(8'h30 + 8'(k));
        send(8'hA5);
        chk("bad_fe", 80'(frame_err), 80'd1);
        chk("bad_fv", 80'(frame_valid), 80'd0);
        chk("bad_idx", 80'(idx), 80'd0);
        chk("bad_w_kept", w_all, seq(8'h10));
        idle();
        chk("bad_fe_end", 80'(frame_err), 80'd0);
        send(8'h01);
        chk("resync_drop_fe", 80'(frame_err), 80'd0);
        chk("resync_idx", 80'(idx), 80'd0);
        send(8'hB7);
        chk("resync_trl_fv", 80'(frame_valid), 80'd0);
        chk("resync_trl_idx", 80'(idx), 80'd0);
        for (int k = 0; k < 10; k++) send(8'h20 + 8'(k));
        send(8'hB7);
        chk("good2_fv", 80'(frame_valid), 80'd1);
        chk("good2_w", w_all, seq(8'h20));
        idle();

        // ---------------- All-trailer-valued data ----------------
        for (int k = 0; k < 10; k++) send(8'hB7);
        chk("allb7_no_early_fv", 80'(frame_valid), 80'd0);
        chk("allb7_idx", 80'(idx), 80'd10);
        send(8'hB7);
        chk("allb7_fv", 80'(frame_valid), 80'd1);
        chk("allb7_w", w_all, {10{8'hB7}});
        idle();

        // ---------------- Gapped frame + byte held over PUBLISH ----------------
        for (int k = 0; k < 10; k++) begin
            send(8'h40 + 8'(k));
            idle();
            if (k == 4) chk("gap_idx_hold", 80'(idx), 80'd5);
        end
        chk("gap_idx10", 80'(idx), 80'd10);
        send(8'hB7);
        chk("gap_fv", 80'(frame_valid), 80'd1);
        chk("gap_w", w_all, seq(8'h40));
        // Offer 8'h55 during the PUBLISH cycle and hold it.
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        chk("held_not_taken_idx", 80'(idx), 80'd0);
        chk("held_fv_end", 80'(frame_valid), 80'd0);
        tick();
        in_valid = 1'b0;
        chk("held_taken_idx", 80'(idx), 80'd1);
        for (int k = 1; k < 10; k++) send(8'h55 + 8'(k));
        send(8'hB7);
        chk("held_fv", 80'(frame_valid), 80'd1);
        chk("held_w", w_all, seq(8'h55));
        idle();

        // ---------------- Reset mid-frame ----------------
        for (int k = 0; k < 6; k++) send(8'h60 + 8'(k));
        chk("mid_idx6", 80'(idx), 80'd6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_w", w_all, 80'd0);
        chk("mid_rst_idx", 80'(idx), 80'd0);
        chk("mid_rst_fv", 80'(frame_valid), 80'd0);
        chk("mid_rst_fe", 80'(frame_err), 80'd0);
        idle();
        chk("mid_rst_quiet", 80'({frame_valid, frame_err}), 80'd0);
        for (int k = 0; k < 10; k++) send(8'h70 + 8'(k));
        send(8'hB7);
        chk("post_rst_fv", 80'(frame_valid), 80'd1);
        chk("post_rst_w", w_all, seq(8'h70));
        idle();
        chk("post_rst_fv_end", 80'(frame_valid), 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
